// File: rtl/alu_logical_serial_ctrl.sv
// Bit-serial sequencer that runs a WIDTH-bit AND/OR/XOR through one 1-bit logical slice,
// LSB first, with a start/busy/done handshake and a registered result/zero flag.

module alu_logical_1_bit (
  input  logic a_i,
  input  logic b_i,
  input  logic sel0_i,
  input  logic sel1_i,
  output logic y_c
);
  logic and_or_c;

  // First mux picks AND/OR, second picks that value or XOR
  always_comb begin
    and_or_c = sel0_i ? (a_i | b_i) : (a_i & b_i);
    y_c      = sel1_i ? (a_i ^ b_i) : and_or_c;
  end
endmodule

module alu_logical_serial_ctrl #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] result_o,
  output logic             zero_o
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, result_q, result_d;
  logic [1:0]       op_q, op_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             busy_q, busy_d, done_q, done_d, zero_q, zero_d;
  logic             accept_c, last_c, slice_y_c;
  logic [WIDTH-1:0] shifted_c;

  alu_logical_1_bit u_slice (
    .a_i    (a_q[0]),
    .b_i    (b_q[0]),
    .sel0_i (op_q[0]),
    .sel1_i (op_q[1]),
    .y_c    (slice_y_c)
  );

  assign accept_c  = start_i && (state_q != RUN);
  assign last_c    = (cnt_q == CW'(WIDTH - 1));
  assign shifted_c = {slice_y_c, result_q[WIDTH-1:1]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      a_q      <= '0;
      b_q      <= '0;
      op_q     <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start_i) state_d = RUN;
      RUN:     if (last_c) state_d = DONE;
      DONE:    state_d = start_i ? RUN : IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath updates and registered status flags
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    zero_d   = zero_q;
    if (accept_c) begin
      a_d   = a_i;
      b_d   = b_i;
      op_d  = op_i;
      cnt_d = '0;
    end else if (state_q == RUN) begin
      result_d = shifted_c;
      a_d      = a_q >> 1;
      b_d      = b_q >> 1;
      if (last_c) begin
        zero_d = (shifted_c == '0);
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign zero_o   = zero_q;
endmodule

// File: tb/tb_alu_logical_serial_ctrl.sv
// Randomized and directed bench for the bit-serial logical sequencer (WIDTH=8 and WIDTH=2 builds).

module tb_alu_logical_serial_ctrl;
  logic       clk = 1'b0;
  logic       rst;
  logic       start, busy, done, zero;
  logic [1:0] op;
  logic [7:0] a, b, result;
  logic       start2, busy2, done2, zero2;
  logic [1:0] op2, a2, b2, result2;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  alu_logical_serial_ctrl #(.WIDTH(8)) dut (
    .clk(clk), .rst(rst), .start_i(start), .op_i(op), .a_i(a), .b_i(b),
    .busy_o(busy), .done_o(done), .result_o(result), .zero_o(zero)
  );

  alu_logical_serial_ctrl #(.WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .start_i(start2), .op_i(op2), .a_i(a2), .b_i(b2),
    .busy_o(busy2), .done_o(done2), .result_o(result2), .zero_o(zero2)
  );

  function automatic logic [7:0] ref_op(input logic [7:0] x, input logic [7:0] y, input logic [1:0] o);
    case (o)
      2'b00:   return x & y;
      2'b01:   return x | y;
      default: return x ^ y;
    endcase
  endfunction

  // Issue one request at a negedge; return at the negedge of the done cycle.
  task automatic do_op(input logic [7:0] xa, input logic [7:0] xb, input logic [1:0] xo,
                       output int nbusy, output int ndone, output logic done_ok,
                       output logic [7:0] res, output logic z);
    start = 1'b1; a = xa; b = xb; op = xo;
    @(negedge clk);
    start = 1'b0;
    nbusy = 0; ndone = 0;
    for (int i = 0; i < 8; i++) begin
      if (busy) nbusy++;
      if (done) ndone++;
      a = 8'($urandom); b = 8'($urandom); op = 2'($urandom);
      @(negedge clk);
    end
    done_ok = done && !busy;
    res = result;
    z = zero;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 0; a = 0; b = 0; op = 0;
    start2 = 0; a2 = 0; b2 = 0; op2 = 0;
    #1;
    n_cmp++;
    if ({busy, done, result, zero} !== 11'd0) begin
      n_err++; $display("FAIL reset_state: got busy=%b done=%b result=%h zero=%b, want all 0", busy, done, result, zero);
    end
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if ({busy, done} !== 2'b00) begin
      n_err++; $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  task automatic test_directed();
    logic [7:0] ta [4] = '{8'hF0, 8'hA5, 8'hFF, 8'h55};
    logic [7:0] tb [4] = '{8'h3C, 8'h0F, 8'hFF, 8'hAA};
    logic [7:0] te [4] = '{8'h30, 8'hAF, 8'h00, 8'hFF};
    int nb, nd; logic ok, z; logic [7:0] r;
    for (int i = 0; i < 4; i++) begin
      do_op(ta[i], tb[i], 2'(i), nb, nd, ok, r, z);
      n_cmp++;
      if (nb != 8 || nd != 0 || !ok) begin
        n_err++; $display("FAIL dir_timing[%0d]: got busy_cycles=%0d early_done=%0d done_ok=%b, want 8 0 1", i, nb, nd, ok);
      end
      n_cmp++;
      if (r !== te[i] || z !== (te[i] == 8'h00)) begin
        n_err++; $display("FAIL dir_result[%0d]: got %h zero=%b, want %h zero=%b", i, r, z, te[i], te[i] == 8'h00);
      end
      @(negedge clk);
      n_cmp++;
      if (done !== 1'b0 || result !== te[i]) begin
        n_err++; $display("FAIL dir_pulse[%0d]: got done=%b result=%h, want 0 %h", i, done, result, te[i]);
      end
    end
  endtask

  task automatic test_start_while_busy();
    int nb = 0, nd = 0;
    start = 1'b1; a = 8'hFF; b = 8'h81; op = 2'b00;
    @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        start = 1'b1; op = 2'b01; a = 8'h00; b = 8'h00;
      end else begin
        start = 1'b0; a = 8'($urandom); b = 8'($urandom);
      end
      if (busy) nb++;
      @(negedge clk);
    end
    n_cmp++;
    if (nb != 8 || done !== 1'b1 || result !== 8'h81) begin
      n_err++; $display("FAIL busy_start: got busy_cycles=%0d done=%b result=%h, want 8 1 81", nb, done, result);
    end
    nb = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) nd++;
    end
    n_cmp++;
    if (nb != 0 || nd != 0 || result !== 8'h81) begin
      n_err++; $display("FAIL busy_start_no_requeue: got busy=%0d done=%0d result=%h, want 0 0 81", nb, nd, result);
    end
  endtask

  task automatic test_back_to_back();
    int nb, nd; logic ok, z; logic [7:0] r;
    do_op(8'h12, 8'h34, 2'b01, nb, nd, ok, r, z);
    do_op(8'h0F, 8'hFF, 2'b10, nb, nd, ok, r, z);
    n_cmp++;
    if (nb != 8 || nd != 0 || !ok || r !== 8'hF0 || z !== 1'b0) begin
      n_err++; $display("FAIL back_to_back: got busy=%0d done_ok=%b result=%h zero=%b, want 8 1 f0 0", nb, ok, r, z);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_run();
    int nb, nd = 0; logic ok, z; logic [7:0] r;
    start = 1'b1; a = 8'hFF; b = 8'hFF; op = 2'b01;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if ({busy, done, result, zero} !== 11'd0) begin
      n_err++; $display("FAIL async_reset: got busy=%b done=%b result=%h zero=%b, want all 0", busy, done, result, zero);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || busy) nd++;
    end
    n_cmp++;
    if (nd != 0) begin
      n_err++; $display("FAIL reset_no_done: got %0d active cycles, want 0", nd);
    end
    do_op(8'h3C, 8'h3C, 2'b00, nb, nd, ok, r, z);
    n_cmp++;
    if (nb != 8 || !ok || r !== 8'h3C) begin
      n_err++; $display("FAIL after_reset_op: got busy=%0d done_ok=%b result=%h, want 8 1 3c", nb, ok, r);
    end
    @(negedge clk);
  endtask

  task automatic test_random();
    int nb, nd; logic ok, z; logic [7:0] r, xa, xb, exp; logic [1:0] xo;
    for (int i = 0; i < 30; i++) begin
      xa = 8'($urandom); xb = 8'($urandom); xo = 2'($urandom);
      if (i % 7 == 0) xb = ~xa;
      exp = ref_op(xa, xb, xo);
      do_op(xa, xb, xo, nb, nd, ok, r, z);
      n_cmp++;
      if (nb != 8 || nd != 0 || !ok || r !== exp || z !== (exp == 8'h00)) begin
        n_err++; $display("FAIL rand[%0d] op=%0d a=%h b=%h: got busy=%0d done_ok=%b result=%h zero=%b, want 8 1 %h %b",
                          i, xo, xa, xb, nb, ok, r, z, exp, exp == 8'h00);
      end
      if ($urandom_range(0, 1) == 1) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_width2();
    logic [1:0] ta [2] = '{2'b10, 2'b11};
    logic [1:0] tb [2] = '{2'b01, 2'b10};
    logic [1:0] to [2] = '{2'b01, 2'b00};
    logic [1:0] te [2] = '{2'b11, 2'b10};
    int nb;
    for (int k = 0; k < 2; k++) begin
      start2 = 1'b1; a2 = ta[k]; b2 = tb[k]; op2 = to[k];
      @(negedge clk);
      start2 = 1'b0; nb = 0;
      for (int i = 0; i < 2; i++) begin
        if (busy2 && !done2) nb++;
        a2 = 2'($urandom); b2 = 2'($urandom);
        @(negedge clk);
      end
      n_cmp++;
      if (nb != 2 || done2 !== 1'b1 || busy2 !== 1'b0 || result2 !== te[k] || zero2 !== 1'b0) begin
        n_err++; $display("FAIL width2[%0d]: got busy=%0d done=%b result=%b zero=%b, want 2 1 %b 0", k, nb, done2, result2, zero2, te[k]);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_start_while_busy();
    test_back_to_back();
    test_reset_mid_run();
    test_random();
    test_width2();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
